// File: rtl/draw_sched.sv
// draw_sched: round-robin arbiter sharing one shape-drawing engine among
// NREQ requesters. Latches the winner's two vertices, pulses eng_start,
// waits for eng_done, then returns a one-cycle ack to the winner.
module draw_sched #(
  parameter int unsigned CORDW = 10,
  parameter int unsigned NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pause,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CORDW-1:0] req_x0,
  input  logic [NREQ*CORDW-1:0] req_y0,
  input  logic [NREQ*CORDW-1:0] req_x1,
  input  logic [NREQ*CORDW-1:0] req_y1,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  eng_start,
  output logic [CORDW-1:0]      eng_x0,
  output logic [CORDW-1:0]      eng_y0,
  output logic [CORDW-1:0]      eng_x1,
  output logic [CORDW-1:0]      eng_y1,
  input  logic                  eng_done
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

  state_t            state, state_n;
  logic [NREQ-1:0]   grant_n, ack_n;
  logic              busy_n, eng_start_n;
  logic [CORDW-1:0]  x0_n, y0_n, x1_n, y1_n;
  logic [PW-1:0]     ptr, ptr_n, win, win_n;

  logic              found;
  logic [PW-1:0]     sel;
  int unsigned       best_d, d;

  // Round-robin pick: the requester at the smallest circular distance
  // upward from the pointer wins.
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    best_d = NREQ;
    d      = 0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      d = j + NREQ - 32'(ptr);
      if (d >= NREQ) d = d - NREQ;
      if (req[j] && (d < best_d)) begin
        best_d = d;
        sel    = PW'(j);
        found  = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n     = state;
    grant_n     = grant;
    ack_n       = ack;
    busy_n      = busy;
    eng_start_n = eng_start;
    x0_n        = eng_x0;
    y0_n        = eng_y0;
    x1_n        = eng_x1;
    y1_n        = eng_y1;
    ptr_n       = ptr;
    win_n       = win;
    case (state)
      IDLE: begin
        if (!pause && found) begin
          grant_n = '0;
          for (int unsigned j = 0; j < NREQ; j++) begin
            if (PW'(j) == sel) begin
              grant_n[j] = 1'b1;
              x0_n = req_x0[j*CORDW +: CORDW];
              y0_n = req_y0[j*CORDW +: CORDW];
              x1_n = req_x1[j*CORDW +: CORDW];
              y1_n = req_y1[j*CORDW +: CORDW];
            end
          end
          win_n       = sel;
          eng_start_n = 1'b1;
          busy_n      = 1'b1;
          state_n     = START;
        end
      end
      START: begin
        eng_start_n = 1'b0;
        state_n     = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          ack_n   = grant;
          grant_n = '0;
          ptr_n   = (32'(win) == NREQ - 1) ? '0 : win + PW'(1);
          state_n = ACK;
        end
      end
      ACK: begin
        ack_n   = '0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset aborts any shape without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      eng_start <= 1'b0;
      eng_x0    <= '0;
      eng_y0    <= '0;
      eng_x1    <= '0;
      eng_y1    <= '0;
      ptr       <= '0;
      win       <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      ack       <= ack_n;
      busy      <= busy_n;
      eng_start <= eng_start_n;
      eng_x0    <= x0_n;
      eng_y0    <= y0_n;
      eng_x1    <= x1_n;
      eng_y1    <= y1_n;
      ptr       <= ptr_n;
      win       <= win_n;
    end
  end

endmodule
